// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffer.
// Holds the state encoding, the default payload width (instruction + PC + PC+4)
// and a helper that reports how many entries each state holds.
package pipe_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned DATA_W_DEFAULT = 3 * XLEN;

  // Plain constants rather than an enum so older stage code can share the encoding.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKIDF = 2'd2;

  // Number of payload entries held in a given state.
  function automatic logic [1:0] held_entries(input logic [1:0] st);
    logic [1:0] n;
    n = 2'd0;
    case (st)
      ST_FULL:  n = 2'd1;
      ST_SKIDF: n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter used for the stage performance counters.
// Ports:
//   clk_i   clock
//   clr_ni  synchronous active-low clear
//   inc_i   amount to add this cycle
//   cnt_o   current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned INC_W = 2
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic [INC_W-1:0] inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + (CNT_W + 1)'(inc_i);
    // Carry out of the top bit means we passed all-ones: clamp.
    cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer.
// Ports:
//   clk        clock, all state on posedge
//   reset      synchronous active-low reset (priority over flush)
//   flush      synchronous clear of all stored entries
//   in_valid   upstream payload valid
//   in_ready   stage can accept a payload this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts out_data this cycle
//   out_data   head entry payload
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
//   drop_cnt   saturating count of entries discarded by flush
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEFAULT,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CLEAR_DATA = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  logic       in_xfer;
  logic       out_xfer;
  logic [1:0] stall_inc;
  logic [1:0] drop_inc;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign out_xfer  = out_valid & out_ready;
  // A flushed cycle never accepts, even though in_ready is left as is.
  assign in_xfer   = in_valid & in_ready & ~flush;

  // With the skid buffer in_ready depends on state only, keeping the upstream
  // ready path registered; without it, ready follows out_ready when full.
  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      if (SKID != 0) begin
        in_ready = (state_q != ST_SKIDF);
      end else begin
        in_ready = (state_q == ST_EMPTY) | out_ready;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end else if (in_xfer && (SKID != 0)) begin
          skid_d  = in_data;
          state_d = ST_SKIDF;
        end
      end
      ST_SKIDF: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
      if (CLEAR_DATA != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end

    // No skid storage exists in the single-entry configuration.
    if (SKID == 0) begin
      skid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Entries lost to a flush are those held minus the one delivered that cycle.
  always_comb begin
    stall_inc = {1'b0, out_valid & ~out_ready};
    drop_inc  = 2'd0;
    if (flush) begin
      drop_inc = held_entries(state_q) - {1'b0, out_xfer};
    end
  end

  sat_counter #(
    .CNT_W (CNT_W),
    .INC_W (2)
  ) u_stall_cnt (
    .clk_i  (clk),
    .clr_ni (reset),
    .inc_i  (stall_inc),
    .cnt_o  (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W),
    .INC_W (2)
  ) u_drop_cnt (
    .clk_i  (clk),
    .clr_ni (reset),
    .inc_i  (drop_inc),
    .cnt_o  (drop_cnt)
  );

endmodule
